// File: rtl/controlador_linha_envase_param.sv
// ============================================================================
//  Module   : controlador_linha_envase_param
//  Purpose  : Parametrised fill/cap line controller. Sequences conveyor, fill
//             valve and capper, counts bottles into batches and manages a
//             two-level cork store (main buffer auto-refilled from secondary).
//  Options  : define FILL_TIMEOUT_EN to abort a FILLING phase that does not
//             see the bottle-full sensor within FILL_TIMEOUT cycles.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module controlador_linha_envase_param #(
  parameter int MAIN_DEPTH   = 20,
  parameter int SEC_DEPTH    = 99,
  parameter int MIN_LEVEL    = 5,
  parameter int TRANSFER_QTY = 15,
  parameter int BATCH        = 12,
  parameter int BATCH_MAX    = 99,
  parameter int FILL_TIMEOUT = 1000,
  localparam int MW = $clog2(MAIN_DEPTH + 1),
  localparam int SW = $clog2(SEC_DEPTH + 1),
  localparam int BW = $clog2(BATCH),
  localparam int KW = $clog2(BATCH_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_stop,
  input  logic          pg,
  input  logic          ch,
  input  logic          cq,
  input  logic          op_load,
  input  logic [SW-1:0] op_qty,
  output logic          m,
  output logic          ve,
  output logic          ev,
  output logic          al,
  output logic          load_err,
  output logic          batch_done,
  output logic [1:0]    estado,
  output logic [MW-1:0] main_level,
  output logic [SW-1:0] sec_level,
  output logic [BW-1:0] bottle_count,
  output logic [KW-1:0] batch_count
);

  // Main sequencing FSM encoding (also the externally visible state code)
  localparam logic [1:0] c_S_IDLE     = 2'b00;
  localparam logic [1:0] c_S_CONVEYOR = 2'b01;
  localparam logic [1:0] c_S_FILLING  = 2'b10;
  localparam logic [1:0] c_S_CAPPING  = 2'b11;

  // Cork transfer FSM encoding
  localparam logic [0:0] c_T_IDLE = 1'b0;
  localparam logic [0:0] c_T_MOVE = 1'b1;

  localparam int RW = $clog2(TRANSFER_QTY + 1);

  localparam logic [MW-1:0] c_main_full   = MW'(MAIN_DEPTH);
  localparam logic [MW-1:0] c_min_level   = MW'(MIN_LEVEL);
  localparam logic [SW:0]   c_sec_full_x  = (SW+1)'(SEC_DEPTH);
  localparam logic [RW-1:0] c_xfer_qty    = RW'(TRANSFER_QTY);
  localparam logic [BW-1:0] c_batch_last  = BW'(BATCH - 1);
  localparam logic [KW-1:0] c_batch_max   = KW'(BATCH_MAX);

  // State and storage registers
  logic [1:0]    r_state;
  logic [0:0]    r_t_state;
  logic [RW-1:0] r_rem;
  logic [MW-1:0] r_main;
  logic [SW-1:0] r_sec;
  logic [BW-1:0] r_bottle;
  logic [KW-1:0] r_batch;
  logic          r_batch_done;
  logic          r_load_err;
  logic          r_ss_prev;

  // Combinational helpers
  logic [1:0]    w_state_next;
  logic          w_consume;
  logic          w_xfer;
  logic          w_rise;
  logic [MW:0]   w_main_calc;
  logic [MW-1:0] w_main_next;
  logic [SW:0]   w_sec_mid;
  logic [SW:0]   w_cand;
  logic          w_load_bad;
  logic          w_load_ok;
  logic [SW-1:0] w_sec_next;
  logic [RW-1:0] w_rem_next;
  logic          w_timeout;
  logic          w_to_latch;

  // One cork leaves the main buffer on the capping-complete cycle
  assign w_consume = (r_state == c_S_CAPPING) && cq && (r_main != '0);

  // One cork moves secondary -> main on every active transfer cycle
  assign w_xfer = (r_t_state == c_T_MOVE) && (r_sec != '0) && (r_main != c_main_full);

  assign w_rise = start_stop && !r_ss_prev;

  // Main level: consume and transfer may coincide and cancel out
  assign w_main_calc = (MW+1)'(r_main) + (MW+1)'(w_xfer) - (MW+1)'(w_consume);
  assign w_main_next = w_main_calc[MW-1:0];

  // Secondary level: transfer decrement first, then the operator offer on top
  assign w_sec_mid  = (SW+1)'(r_sec) - (SW+1)'(w_xfer);
  assign w_cand     = w_sec_mid + (SW+1)'(op_qty);
  assign w_load_bad = op_load && ((w_cand > c_sec_full_x) || (op_qty == '0));
  assign w_load_ok  = op_load && !w_load_bad;
  assign w_sec_next = w_load_ok ? w_cand[SW-1:0] : w_sec_mid[SW-1:0];

  assign w_rem_next = r_rem - RW'(w_xfer);

`ifdef FILL_TIMEOUT_EN
  localparam int FW = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
  localparam logic [FW-1:0] c_fill_last = FW'(FILL_TIMEOUT - 1);

  logic [FW-1:0] r_fill_cnt;
  logic          r_to_latch;

  // Timeout fires on the last allowed FILLING cycle without the full sensor
  assign w_timeout  = (r_state == c_S_FILLING) && !ch && (r_fill_cnt == c_fill_last);
  assign w_to_latch = r_to_latch;

  // Fill watchdog counter and sticky alarm (cleared by a stop request)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_cnt <= '0;
      r_to_latch <= 1'b0;
    end else begin
      if ((r_state == c_S_FILLING) && !ch && !w_timeout) begin
        r_fill_cnt <= r_fill_cnt + FW'(1);
      end else begin
        r_fill_cnt <= '0;
      end
      if (w_timeout) begin
        r_to_latch <= 1'b1;
      end else if (!start_stop) begin
        r_to_latch <= 1'b0;
      end
    end
  end
`else
  // No watchdog: FILLING waits on the full sensor indefinitely. The
  // comparison below is constant-false and only keeps the parameter bound.
  assign w_timeout  = 1'b0;
  assign w_to_latch = (FILL_TIMEOUT < 0);
`endif

  // Main FSM next-state decision
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (start_stop && (r_main != '0) && !w_to_latch) begin
          w_state_next = c_S_CONVEYOR;
        end
      end
      c_S_CONVEYOR: begin
        if (!start_stop) begin
          w_state_next = c_S_IDLE;
        end else if (pg) begin
          // Never start a bottle that cannot be capped
          w_state_next = (r_main != '0) ? c_S_FILLING : c_S_IDLE;
        end
      end
      c_S_FILLING: begin
        if (ch) begin
          w_state_next = c_S_CAPPING;
        end else if (w_timeout) begin
          w_state_next = c_S_IDLE;
        end
      end
      default: begin
        if (cq) begin
          w_state_next = (start_stop && (w_main_next != '0)) ? c_S_CONVEYOR : c_S_IDLE;
        end
      end
    endcase
  end

  // Main FSM state register and run-request edge tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_S_IDLE;
      r_ss_prev <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ss_prev <= start_stop;
    end
  end

  // Transfer FSM: burst of up to TRANSFER_QTY corks when main runs low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t_state <= c_T_IDLE;
      r_rem     <= '0;
    end else begin
      case (r_t_state)
        c_T_IDLE: begin
          if ((r_main <= c_min_level) && (r_sec != '0)) begin
            r_t_state <= c_T_MOVE;
            r_rem     <= c_xfer_qty;
          end
        end
        default: begin
          r_rem <= w_rem_next;
          if ((w_rem_next == '0) || (w_main_next == c_main_full) ||
              (w_sec_next == '0) || !w_xfer) begin
            r_t_state <= c_T_IDLE;
          end
        end
      endcase
    end
  end

  // Cork levels and operator-load reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main     <= c_main_full;
      r_sec      <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_main     <= w_main_next;
      r_sec      <= w_sec_next;
      r_load_err <= w_load_bad;
    end
  end

  // Bottle / batch counting; a fresh run request in IDLE starts a new tally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bottle     <= '0;
      r_batch      <= '0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      if ((r_state == c_S_IDLE) && w_rise) begin
        r_bottle <= '0;
        r_batch  <= '0;
      end else if (w_consume) begin
        if (r_bottle == c_batch_last) begin
          r_bottle     <= '0;
          r_batch      <= (r_batch == c_batch_max) ? '0 : r_batch + KW'(1);
          r_batch_done <= 1'b1;
        end else begin
          r_bottle <= r_bottle + BW'(1);
        end
      end
    end
  end

  // Moore outputs decoded from the registered state
  assign m  = (r_state == c_S_CONVEYOR);
  assign ve = (r_state == c_S_FILLING);
  assign ev = (r_state == c_S_CAPPING);

  // Starvation alarm while a run is requested with an empty main buffer
  assign al = (start_stop && (r_main == '0) &&
               ((r_state == c_S_IDLE) || (r_state == c_S_CONVEYOR))) || w_to_latch;

  assign load_err     = r_load_err;
  assign batch_done   = r_batch_done;
  assign estado       = r_state;
  assign main_level   = r_main;
  assign sec_level    = r_sec;
  assign bottle_count = r_bottle;
  assign batch_count  = r_batch;

endmodule

`default_nettype wire

// File: tb/tb_controlador_linha_envase_param.sv
// ============================================================================
//  Module   : tb_controlador_linha_envase_param
//  Purpose  : Self-checking bench for controlador_linha_envase_param. Directed
//             scenarios plus randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_linha_envase_param;

  localparam int MAIN_DEPTH   = 20;
  localparam int SEC_DEPTH    = 99;
  localparam int MIN_LEVEL    = 5;
  localparam int TRANSFER_QTY = 15;
  localparam int BATCH        = 12;
  localparam int BATCH_MAX    = 99;
`ifdef FILL_TIMEOUT_EN
  localparam int FILL_TIMEOUT = 8;
  localparam bit TO_EN        = 1'b1;
`else
  localparam int FILL_TIMEOUT = 1000;
  localparam bit TO_EN        = 1'b0;
`endif
  localparam int MW = $clog2(MAIN_DEPTH + 1);
  localparam int SW = $clog2(SEC_DEPTH + 1);
  localparam int BW = $clog2(BATCH);
  localparam int KW = $clog2(BATCH_MAX + 1);

  logic          clk = 1'b0;
  logic          rst, start_stop, pg, ch, cq, op_load;
  logic [SW-1:0] op_qty;
  logic          m, ve, ev, al, load_err, batch_done;
  logic [1:0]    estado;
  logic [MW-1:0] main_level;
  logic [SW-1:0] sec_level;
  logic [BW-1:0] bottle_count;
  logic [KW-1:0] batch_count;

  always #5 clk = ~clk;

  controlador_linha_envase_param #(
    .MAIN_DEPTH  (MAIN_DEPTH),
    .SEC_DEPTH   (SEC_DEPTH),
    .MIN_LEVEL   (MIN_LEVEL),
    .TRANSFER_QTY(TRANSFER_QTY),
    .BATCH       (BATCH),
    .BATCH_MAX   (BATCH_MAX),
    .FILL_TIMEOUT(FILL_TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_stop  (start_stop),
    .pg          (pg),
    .ch          (ch),
    .cq          (cq),
    .op_load     (op_load),
    .op_qty      (op_qty),
    .m           (m),
    .ve          (ve),
    .ev          (ev),
    .al          (al),
    .load_err    (load_err),
    .batch_done  (batch_done),
    .estado      (estado),
    .main_level  (main_level),
    .sec_level   (sec_level),
    .bottle_count(bottle_count),
    .batch_count (batch_count)
  );

  int total = 0;
  int bad   = 0;
  int bd_pulses = 0;

  // Reference model state: phase 0=idle 1=conveyor 2=filling 3=capping
  int md_ph, md_moving, md_left, md_main, md_sec, md_bottles, md_batches;
  int md_bd, md_le, md_ss_prev, md_alarm_latch, md_fill_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int cons, mv, nmain, nsec, cand, nph, nbot, nbat, nbd, nle, nmov, nleft, nlatch, nfill;
    bit rise;
    if (rst) begin
      md_ph = 0; md_moving = 0; md_left = 0; md_main = MAIN_DEPTH; md_sec = 0;
      md_bottles = 0; md_batches = 0; md_bd = 0; md_le = 0; md_ss_prev = 0;
      md_alarm_latch = 0; md_fill_cycles = 0;
      return;
    end
    cons  = (md_ph == 3 && cq) ? 1 : 0;
    mv    = (md_moving != 0 && md_sec > 0 && md_main < MAIN_DEPTH) ? 1 : 0;
    nmain = md_main - cons + mv;
    nsec  = md_sec - mv;
    nle   = 0;
    if (op_load) begin
      cand = nsec + int'(op_qty);
      if (cand > SEC_DEPTH || op_qty == 0) nle = 1;
      else nsec = cand;
    end
    // Transfer burst bookkeeping
    nmov = md_moving; nleft = md_left;
    if (md_moving == 0) begin
      if (md_main <= MIN_LEVEL && md_sec > 0) begin
        nmov = 1; nleft = TRANSFER_QTY;
      end
    end else begin
      nleft = md_left - mv;
      if (nleft == 0 || nmain == MAIN_DEPTH || nsec == 0) nmov = 0;
    end
    // Line sequencing and batch counting
    rise   = start_stop && (md_ss_prev == 0);
    nph    = md_ph; nbot = md_bottles; nbat = md_batches; nbd = 0;
    nlatch = (start_stop) ? md_alarm_latch : 0;
    nfill  = 0;
    case (md_ph)
      0: begin
        if (rise) begin nbot = 0; nbat = 0; end
        if (start_stop && md_main > 0 && md_alarm_latch == 0) nph = 1;
      end
      1: begin
        if (!start_stop) nph = 0;
        else if (pg) nph = (md_main > 0) ? 2 : 0;
      end
      2: begin
        if (ch) nph = 3;
        else if (TO_EN && md_fill_cycles == FILL_TIMEOUT - 1) begin nph = 0; nlatch = 1; end
        else nfill = md_fill_cycles + 1;
      end
      default: begin
        if (cq) begin
          nbot = (md_bottles + 1) % BATCH;
          if (nbot == 0) begin
            nbat = (md_batches + 1) % (BATCH_MAX + 1);
            nbd  = 1;
          end
          nph = (start_stop && nmain > 0) ? 1 : 0;
        end
      end
    endcase
    md_ph = nph; md_moving = nmov; md_left = nleft; md_main = nmain; md_sec = nsec;
    md_bottles = nbot; md_batches = nbat; md_bd = nbd; md_le = nle;
    md_ss_prev = start_stop; md_alarm_latch = nlatch; md_fill_cycles = nfill;
  endtask

  task automatic check_all();
    int exp_al;
    exp_al = ((start_stop && md_main == 0 && md_ph <= 1) || md_alarm_latch != 0) ? 1 : 0;
    chk("estado",       estado,       md_ph);
    chk("main_level",   main_level,   md_main);
    chk("sec_level",    sec_level,    md_sec);
    chk("bottle_count", bottle_count, md_bottles);
    chk("batch_count",  batch_count,  md_batches);
    chk("m",            m,            (md_ph == 1) ? 1 : 0);
    chk("ve",           ve,           (md_ph == 2) ? 1 : 0);
    chk("ev",           ev,           (md_ph == 3) ? 1 : 0);
    chk("al",           al,           exp_al);
    chk("load_err",     load_err,     md_le);
    chk("batch_done",   batch_done,   md_bd);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (batch_done === 1'b1) bd_pulses++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_stop = 1'b0; pg = 1'b0; ch = 1'b0; cq = 1'b0;
    op_load = 1'b0; op_qty = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic bottle();
    pg = 1'b1; cyc(); pg = 1'b0;
    ch = 1'b1; cyc(); ch = 1'b0;
    cq = 1'b1; cyc(); cq = 1'b0;
  endtask

  task automatic load(input int q);
    op_load = 1'b1; op_qty = SW'(q); cyc();
    op_load = 1'b0; op_qty = '0;
  endtask

  task automatic count_moves(input int cycles, output int moves);
    int prev;
    prev  = main_level;
    moves = 0;
    repeat (cycles) begin
      cyc();
      if (int'(main_level) > prev) moves++;
      prev = main_level;
    end
  endtask

  initial begin
    int moves, m0, s0;

    // Reset values
    do_reset();
    chk("rst_estado", estado, 0);
    chk("rst_main", main_level, MAIN_DEPTH);
    chk("rst_sec", sec_level, 0);
    chk("rst_outs", {m, ve, ev, al, load_err, batch_done}, 0);

    // One full bottle cycle
    start_stop = 1'b1;
    cyc();
    chk("seq_conv", {estado, m, ve, ev}, {2'b01, 3'b100});
    pg = 1'b1; cyc(); pg = 1'b0;
    chk("seq_fill", {estado, m, ve, ev}, {2'b10, 3'b010});
    ch = 1'b1; cyc(); ch = 1'b0;
    chk("seq_cap", {estado, m, ve, ev}, {2'b11, 3'b001});
    cq = 1'b1; cyc(); cq = 1'b0;
    chk("seq_back", estado, 1);
    chk("seq_main", main_level, 19);
    chk("seq_bottles", bottle_count, 1);

    // Complete the batch
    bd_pulses = 0;
    repeat (11) bottle();
    cyc();
    chk("batch_bottles", bottle_count, 0);
    chk("batch_count", batch_count, 1);
    chk("batch_pulses", bd_pulses, 1);

    // Restart in IDLE clears the tally
    start_stop = 1'b0; cyc();
    start_stop = 1'b1; cyc();
    chk("restart_clear", {bottle_count, batch_count}, 0);

    // Low-level transfer: main 8 -> 5 with 40 corks in secondary
    load(40);
    repeat (3) bottle();
    start_stop = 1'b0;
    count_moves(20, moves);
    chk("xfer40_moves", moves, 15);
    chk("xfer40_main", main_level, 20);
    chk("xfer40_sec", sec_level, 25);

    // Transfer limited by a small secondary store
    do_reset();
    start_stop = 1'b1; cyc();
    load(3);
    repeat (15) bottle();
    start_stop = 1'b0;
    count_moves(12, moves);
    chk("xfer3_moves", moves, 3);
    chk("xfer3_main", main_level, 8);
    chk("xfer3_sec", sec_level, 0);

    // Capping consume coincident with a transfer move
    do_reset();
    start_stop = 1'b1; cyc();
    load(40);
    repeat (15) bottle();
    pg = 1'b1; cyc(); pg = 1'b0;
    ch = 1'b1; cyc(); ch = 1'b0;
    m0 = main_level; s0 = sec_level;
    cq = 1'b1; cyc(); cq = 1'b0;
    chk("coinc_main", main_level, m0);
    chk("coinc_total", int'(main_level) + int'(sec_level), m0 + s0 - 1);
    start_stop = 1'b0;
    repeat (20) cyc();

    // Operator loads: overflow reject, exact fill, zero reject
    do_reset();
    load(90);
    chk("load90", sec_level, 90);
    load(10);
    chk("load10_sec", sec_level, 90);
    chk("load10_err", load_err, 1);
    cyc();
    chk("load_err_clr", load_err, 0);
    load(9);
    chk("load9_sec", sec_level, 99);
    chk("load9_err", load_err, 0);
    load(0);
    chk("load0_sec", sec_level, 99);
    chk("load0_err", load_err, 1);

    // Fill phase without the full sensor
    do_reset();
    start_stop = 1'b1; cyc();
    pg = 1'b1; cyc(); pg = 1'b0;
`ifdef FILL_TIMEOUT_EN
    repeat (FILL_TIMEOUT) cyc();
    chk("to_state", estado, 0);
    chk("to_alarm", al, 1);
    chk("to_valve", ve, 0);
    chk("to_main", main_level, MAIN_DEPTH);
    cyc();
    chk("to_hold", {estado, al}, {2'b00, 1'b1});
    start_stop = 1'b0; cyc();
    chk("to_clear", al, 0);
`else
    repeat (1000) cyc();
    chk("nto_state", estado, 2);
    chk("nto_alarm", al, 0);
    ch = 1'b1; cyc(); ch = 1'b0;
    chk("nto_cap", estado, 3);
`endif

    // Randomized traffic with occasional mid-run resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      start_stop = ($urandom_range(0, 19) != 0);
      pg         = ($urandom_range(0, 2) == 0);
      ch         = ($urandom_range(0, 2) == 0);
      cq         = ($urandom_range(0, 2) == 0);
      op_load    = ($urandom_range(0, 5) == 0);
      op_qty     = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, (1 << SW) - 1))
                                               : SW'($urandom_range(0, 25));
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
